pea_controller: RTL and testbench

PEA_CONTROLLER -- requirements
Module: pea_controller

---
 rtl/pea_if.sv | 28 ++
 rtl/pea_controller.sv | 196 +++++++++++++++++++
 tb/tb_pea_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pea_if.sv
// pea_if: FIFO-side handshake/bus bundle between pea_controller and its command/data/result/status FIFOs
interface pea_if #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
);
  localparam int AW = $clog2(buffer_size);
  logic [AW-1:0]        command_pop;
  logic [AW-1:0]        data_pop;
  logic [AW-1:0]        result_free_space;
  logic [AW-1:0]        status_free_space;
  logic [word_size-1:0] command_in;
  logic [word_size-1:0] data_in;
  logic [word_size-1:0] result_out;
  logic [word_size-1:0] status_out;
  logic                 command_rd_en;
  logic                 data_rd_en;
  logic                 result_wr_en;
  logic                 status_wr_en;
  logic                 busy;
  modport slave (
    input  command_pop, data_pop, result_free_space, status_free_space, command_in, data_in,
    output command_rd_en, data_rd_en, result_out, status_out, result_wr_en, status_wr_en, busy
  );
  modport master (
    output command_pop, data_pop, result_free_space, status_free_space, command_in, data_in,
    input  command_rd_en, data_rd_en, result_out, status_out, result_wr_en, status_wr_en, busy
  );
endinterface

// File: rtl/pea_controller.sv
// pea_controller: polynomial evaluation controller (STP/EVP/EVB/RST commands over FIFOs, Horner datapath).
// Optional feature: define PEA_OVERFLOW_FLAG_EN to report Horner overflow in status bit1.
module pea_controller #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
) (
  input logic  clk,
  input logic  rst,
  pea_if.slave io
);
  localparam int W  = word_size;
  localparam int AW = $clog2(buffer_size);
  localparam logic [1:0] OP_STP = 2'd0;
  localparam logic [1:0] OP_EVP = 2'd1;
  localparam logic [1:0] OP_EVB = 2'd2;
  typedef enum logic [2:0] {IDLE, CMD, WAIT, LOAD, FETCH, HORNER, WRITE, DONE} state_t;
  state_t          state_q;
  logic [1:0]      op_q, id_q;
  logic [4:0]      arg_q, cnt_q;
  logic [3:0]      valid_q, rem_q, k_q, j_q, rd_idx;
  logic [3:0][3:0] deg_q;
  logic [W-1:0]    acc_q, x_q, res_q, sts_q, coef_rd, acc_d;
  logic [W-1:0]    coef_q [4][16];
  logic            cmd_rd_q, dat_rd_q, res_wr_q, sts_wr_q, busy_q, dv_q, go_d;
  logic [AW-1:0]   n1_a, b_a, bs_a;
`ifdef PEA_OVERFLOW_FLAG_EN
  logic [2*W-1:0]  prod_d;
  logic [W:0]      sum_d;
  logic            ovf_q, step_ovf_d;
`endif
  assign io.command_rd_en = cmd_rd_q;
  assign io.data_rd_en    = dat_rd_q;
  assign io.result_wr_en  = res_wr_q;
  assign io.status_wr_en  = sts_wr_q;
  assign io.result_out    = res_q;
  assign io.status_out    = sts_q;
  assign io.busy          = busy_q;
  // WAIT exit condition: enough input words and output room for the whole operation
  always_comb begin
    n1_a = AW'({1'b0, arg_q[3:0]} + 5'd1);
    b_a  = AW'(arg_q);
    bs_a = (arg_q == 5'd0) ? AW'(1) : b_a;
    go_d = (op_q == OP_STP) ? (io.data_pop >= n1_a && io.status_free_space != '0) :
           (op_q == OP_EVP) ? (io.data_pop != '0 && io.result_free_space != '0 && io.status_free_space != '0) :
           (op_q == OP_EVB) ? (io.data_pop >= b_a && io.result_free_space >= b_a && io.status_free_space >= bs_a) :
           1'b1;
  end
  // coefficient read port: top coefficient when starting, c[j-1] while stepping Horner
  always_comb begin
    rd_idx  = (state_q == HORNER) ? j_q - 4'd1 : deg_q[id_q];
    coef_rd = coef_q[id_q][rd_idx];
  end
`ifdef PEA_OVERFLOW_FLAG_EN
  // Horner step at double width so the product and sum carry-outs can be seen
  always_comb begin
    prod_d     = {{W{1'b0}}, acc_q} * {{W{1'b0}}, x_q};
    sum_d      = {1'b0, prod_d[W-1:0]} + {1'b0, coef_rd};
    acc_d      = sum_d[W-1:0];
    step_ovf_d = (|prod_d[2*W-1:W]) | sum_d[W];
  end
`else
  // Horner step truncated to the token width
  always_comb acc_d = acc_q * x_q + coef_rd;
`endif
  // coefficient storage written as STP data words arrive, highest degree first
  always_ff @(posedge clk) begin
    if (state_q == LOAD && dv_q) coef_q[id_q][k_q] <= io.data_in;
  end
  // control FSM with registered strobes, outputs and busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      id_q     <= '0;
      arg_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
      rem_q    <= '0;
      k_q      <= '0;
      j_q      <= '0;
      deg_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      res_q    <= '0;
      sts_q    <= '0;
      cmd_rd_q <= 1'b0;
      dat_rd_q <= 1'b0;
      res_wr_q <= 1'b0;
      sts_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      dv_q     <= 1'b0;
`ifdef PEA_OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      cmd_rd_q <= 1'b0;
      dat_rd_q <= 1'b0;
      res_wr_q <= 1'b0;
      sts_wr_q <= 1'b0;
      dv_q     <= dat_rd_q;
      case (state_q)
        IDLE: if (io.command_pop != '0) begin
          cmd_rd_q <= 1'b1;
          busy_q   <= 1'b1;
          state_q  <= CMD;
        end
        CMD: if (!cmd_rd_q) begin
          op_q    <= io.command_in[1:0];
          id_q    <= io.command_in[3:2];
          arg_q   <= io.command_in[8:4];
          state_q <= WAIT;
        end
        WAIT: if (go_d) begin
          if (op_q == OP_STP) begin
            valid_q[id_q] <= 1'b0;
            dat_rd_q      <= 1'b1;
            rem_q         <= arg_q[3:0];
            k_q           <= arg_q[3:0];
            state_q       <= LOAD;
          end else if (op_q == OP_EVP || (op_q == OP_EVB && arg_q != 5'd0)) begin
            cnt_q    <= (op_q == OP_EVB) ? arg_q : 5'd1;
            dat_rd_q <= 1'b1;
            state_q  <= FETCH;
          end else begin
            valid_q  <= (op_q == OP_EVB) ? valid_q : 4'd0;
            sts_q    <= (op_q == OP_EVB) ? W'(0) : W'(1);
            sts_wr_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        LOAD: begin
          if (rem_q != 4'd0) begin
            dat_rd_q <= 1'b1;
            rem_q    <= rem_q - 4'd1;
          end
          if (dv_q) begin
            k_q <= k_q - 4'd1;
            if (k_q == 4'd0) begin
              deg_q[id_q]   <= arg_q[3:0];
              valid_q[id_q] <= 1'b1;
              sts_q         <= W'(1);
              sts_wr_q      <= 1'b1;
              state_q       <= DONE;
            end
          end
        end
        FETCH: if (dv_q) begin
          x_q   <= io.data_in;
          acc_q <= coef_rd;
          j_q   <= deg_q[id_q];
`ifdef PEA_OVERFLOW_FLAG_EN
          ovf_q <= 1'b0;
`endif
          if (!valid_q[id_q] || deg_q[id_q] == 4'd0) begin
            res_q    <= valid_q[id_q] ? coef_rd : '0;
            sts_q    <= W'(valid_q[id_q]);
            res_wr_q <= 1'b1;
            sts_wr_q <= 1'b1;
            state_q  <= WRITE;
          end else begin
            state_q <= HORNER;
          end
        end
        HORNER: begin
          acc_q <= acc_d;
          j_q   <= j_q - 4'd1;
`ifdef PEA_OVERFLOW_FLAG_EN
          ovf_q <= ovf_q | step_ovf_d;
`endif
          if (j_q == 4'd1) begin
            res_q    <= acc_d;
`ifdef PEA_OVERFLOW_FLAG_EN
            sts_q    <= W'({ovf_q | step_ovf_d, 1'b1});
`else
            sts_q    <= W'(1);
`endif
            res_wr_q <= 1'b1;
            sts_wr_q <= 1'b1;
            state_q  <= WRITE;
          end
        end
        WRITE: if (cnt_q > 5'd1) begin
          cnt_q    <= cnt_q - 5'd1;
          dat_rd_q <= 1'b1;
          state_q  <= FETCH;
        end else begin
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pea_controller.sv
// tb_pea_controller: randomized scoreboard bench for pea_controller with FIFO models and a polynomial reference model
module tb_pea_controller;
  localparam int W  = 16;
  localparam int BS = 1024;
  localparam int AW = $clog2(BS);
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pea_if #(.word_size(W), .buffer_size(BS)) io ();
  pea_controller #(.word_size(W), .buffer_size(BS)) dut (.clk(clk), .rst(rst), .io(io));
  logic [W-1:0] cmd_q[$], dat_q[$], exp_res[$], exp_sts[$];
  logic [W-1:0] mc [4][16];
  int           mdeg [4];
  bit           mval [4];
  logic [W-1:0] w [16];
  int checks = 0;
  int passes = 0;
  int pops = 0;
  int wr_seen = 0;
  logic cr, dr;
  int p0, w0, t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] tok(input int op, input int id, input int arg);
    return W'((arg << 4) | (id << 2) | op);
  endfunction

  // reference: sum of c[i]*x^i in the ring of W-bit integers
  function automatic logic [W-1:0] poly(input int id, input logic [W-1:0] x);
    logic [W-1:0] s, p;
    s = '0;
    p = W'(1);
    for (int i = 0; i <= mdeg[id]; i++) begin
      s = s + mc[id][i] * p;
      p = p * x;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] ovf_bit(input int id, input logic [W-1:0] x);
`ifdef PEA_OVERFLOW_FLAG_EN
    longint acc, p, s;
    bit o;
    acc = longint'(mc[id][mdeg[id]]);
    o = 1'b0;
    for (int k = mdeg[id] - 1; k >= 0; k--) begin
      p = acc * longint'(x);
      s = (p % (64'd1 << W)) + longint'(mc[id][k]);
      if ((p >> W) != 0 || (s >> W) != 0) o = 1'b1;
      acc = s % (64'd1 << W);
    end
    return o ? W'(2) : W'(0);
`else
    return (id < 0 || x === 'x) ? W'(2) : W'(0);
`endif
  endfunction

  task automatic stp(input int id, input int n);
    cmd_q.push_back(tok(0, id, n));
    for (int i = 0; i <= n; i++) begin
      dat_q.push_back(w[i]);
      mc[id][n-i] = w[i];
    end
    mdeg[id] = n;
    mval[id] = 1'b1;
    exp_sts.push_back(W'(1));
  endtask

  task automatic evx(input int id, input logic [W-1:0] x);
    dat_q.push_back(x);
    exp_res.push_back(mval[id] ? poly(id, x) : W'(0));
    exp_sts.push_back(mval[id] ? (W'(1) | ovf_bit(id, x)) : W'(0));
  endtask

  task automatic evp(input int id, input logic [W-1:0] x);
    cmd_q.push_back(tok(1, id, int'($urandom_range(0, 31))));
    evx(id, x);
  endtask

  task automatic evb(input int id, input int b);
    cmd_q.push_back(tok(2, id, b));
    if (b == 0) exp_sts.push_back(W'(0));
    for (int i = 0; i < b; i++) evx(id, W'($urandom));
  endtask

  task automatic rstc();
    cmd_q.push_back(tok(3, int'($urandom_range(0, 3)), int'($urandom_range(0, 31))));
    for (int i = 0; i < 4; i++) mval[i] = 1'b0;
    exp_sts.push_back(W'(1));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || dat_q.size() != 0 || exp_res.size() != 0 || exp_sts.size() != 0 || io.busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 5000) passes++;
    else $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
  endtask

  // FIFO models: a pop strobe seen in one cycle delivers its word in the next
  initial begin
    io.command_in  = '0;
    io.data_in     = '0;
    io.command_pop = '0;
    io.data_pop    = '0;
    forever begin
      @(negedge clk);
      cr = io.command_rd_en;
      dr = io.data_rd_en;
      @(posedge clk);
      #1;
      if (cr) begin
        if (cmd_q.size() == 0) begin
          checks++;
          $display("FAIL command_underflow: got pop of empty FIFO, required none");
        end else io.command_in = cmd_q.pop_front();
      end
      if (dr) begin
        pops++;
        if (dat_q.size() == 0) begin
          checks++;
          $display("FAIL data_underflow: got pop of empty FIFO, required none");
        end else io.data_in = dat_q.pop_front();
      end
      io.command_pop = AW'(cmd_q.size());
      io.data_pop    = AW'(dat_q.size());
    end
  end

  // scoreboard monitor: every write strobe is matched against the next expected token
  initial forever begin
    @(negedge clk);
    if (io.result_wr_en || io.status_wr_en) wr_seen++;
    if (io.result_wr_en) begin
      if (exp_res.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got %h, required no write", io.result_out);
      end else check("result", io.result_out, exp_res.pop_front());
    end
    if (io.status_wr_en) begin
      if (exp_sts.size() == 0) begin
        checks++;
        $display("FAIL unexpected_status: got %h, required no write", io.status_out);
      end else check("status", io.status_out, exp_sts.pop_front());
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mval[i] = 1'b0;
      mdeg[i] = 0;
    end
    io.result_free_space = AW'(512);
    io.status_free_space = AW'(512);
    repeat (3) @(negedge clk);
    check("reset_busy", W'(io.busy), W'(0));
    check("reset_strobes", W'({io.command_rd_en, io.data_rd_en, io.result_wr_en, io.status_wr_en}), W'(0));
    check("reset_result_out", io.result_out, W'(0));
    check("reset_status_out", io.status_out, W'(0));
    rst = 1'b1;
    @(negedge clk);
    w[0] = W'(1); w[1] = W'(2); w[2] = W'(3);
    stp(0, 2);
    evp(0, W'(2));
    check("model_x2_2x_3", exp_res[0], W'(11));
    drain("stp_evp");
    cmd_q.push_back(tok(2, 0, 3));
    evx(0, W'(0)); evx(0, W'(1)); evx(0, W'(5));
    drain("evb3");
    w[0] = W'(16'h0100); w[1] = W'(0);
    stp(1, 1);
    evp(1, W'(16'h0100));
    drain("overflow_case");
    evb(1, 0);
    drain("evb0");
    io.result_free_space = AW'(3);
    p0 = pops;
    w0 = wr_seen;
    evb(0, 4);
    repeat (20) @(negedge clk);
    check("stall_busy", W'(io.busy), W'(1));
    check("stall_no_pops", W'(pops - p0), W'(0));
    check("stall_no_writes", W'(wr_seen - w0), W'(0));
    io.result_free_space = AW'(4);
    drain("stall_release");
    io.result_free_space = AW'(512);
    rstc();
    evp(0, W'(7));
    drain("rst_cmd");
    for (int r = 0; r < 48; r++) begin
      int k, id;
      k  = int'($urandom_range(0, 9));
      id = int'($urandom_range(0, 3));
      if (k < 3) begin
        int n;
        n = int'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) w[i] = W'($urandom);
        stp(id, n);
      end else if (k < 6) evp(id, (k == 5) ? W'($urandom_range(0, 3)) : W'($urandom));
      else if (k < 9) evb(id, int'($urandom_range(0, 6)));
      else rstc();
      if (r % 8 == 7) drain("random");
    end
    drain("random_end");
    for (int i = 0; i < 16; i++) w[i] = W'($urandom);
    stp(2, 15);
    drain("stp15");
    cmd_q.push_back(tok(1, 2, 0));
    dat_q.push_back(W'(16'h1234));
    t = 0;
    while (!io.data_rd_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t < 100) passes++;
    else $display("FAIL x_pop_timeout: no data pop after %0d cycles, required one", t);
    repeat (5) @(negedge clk);
    w0 = wr_seen;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mval[i] = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(io.busy), W'(0));
    check("abort_strobes", W'({io.command_rd_en, io.data_rd_en, io.result_wr_en, io.status_wr_en}), W'(0));
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_writes", W'(wr_seen - w0), W'(0));
    check("abort_idle", W'(io.busy), W'(0));
    evp(2, W'(3));
    evp(0, W'(7));
    drain("post_abort");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
